fpu_mem_arbiter: RTL and testbench
==================================

Name: fpu_mem_arbiter

Overview:
- Downstream memory server for the FPU job manager's four mem_handle ports (a, b, c, d).
- Serialises their read/write requests onto one behavioural scratchpad SRAM.
- Returns read data with a sticky done handshake, so a linear-layer FSM waiting on several ports at once sees each port complete independently.
- Round-robin arbitration, at most one access in flight.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, ptr width per port.
- MEM_DEPTH, 1024, SRAM words; internal index uses log2(MEM_DEPTH) low bits of ptr.
- RD_LAT, 1, SRAM read latency in cycles (legal 1..4).

Ports:
- clk  in  1  clock
- rst_l  in  1  synchronous active-low reset
- avail  in  4  per-port request valid; bit0=a, 1=b, 2=c, 3=d
- r_en  in  4  per-port read request
- w_en  in  4  per-port write request
- ptr  in  4*ADDR_W  per-port word address; port i at [i*ADDR_W +: ADDR_W]
- wdata  in  4*DATA_W  per-port write data
- done  out  4  per-port completion, sticky while avail held
- rdata  out  4*DATA_W  per-port read data, held while done high
- err  out  4  per-port out-of-range flag (optional feature; tied 0 when compiled out)

Behaviour:
- Reset: one clock, synchronous active-low. On a clk edge with rst_l=0:
  - all per-port states go to IDLE; arbiter goes to ARB_IDLE; rr_ptr=0.
  - done=0, err=0, rdata=0.
  - SRAM contents are not cleared.
  - Reset mid-access abandons the access; a write already in its write cycle may or may not land.
- Per-port state machine:
  - IDLE -> PEND when avail&(r_en|w_en).
  - PEND -> BUSY on grant.
  - BUSY -> CPL when the access finishes.
  - CPL -> IDLE when avail=0.
  - Port in CPL ignores r_en/w_en; avail must be observed low at least one cycle before a new request is accepted.
- Request qualifiers:
  - avail=1 with r_en=w_en=0: ignored, no done.
  - r_en=w_en=1: treated as write.
  - ptr, wdata and r_en/w_en are sampled at grant; changes after grant are ignored.
- Arbiter states:
  - ARB_IDLE: if any port in PEND, grant the first PEND port at or after rr_ptr (mod 4); rr_ptr <= grant+1; go to READ_WAIT or WRITE.
  - WRITE: one cycle; SRAM written at its end.
  - READ_WAIT: counter runs RD_LAT cycles.
  - Both then return to ARB_IDLE.
- Timing. Cycle 0 is the first cycle avail is high, port and arbiter idle:
  - grant at end of cycle 0, access cycle 1.
  - Write: done=1 from cycle 2.
  - Read: done=1 and rdata valid from cycle 1+RD_LAT.
  - Arbiter can grant the next PEND port in the cycle done rises; back-to-back grants every 2 cycles (write) or RD_LAT+1 cycles (read).
- done[i] = cpl_flag[i] & avail[i]; it drops combinationally in the same cycle avail drops.
- rdata[i] holds its last read value until that port's next read completes. Writes leave rdata unchanged.
- Out-of-range ptr (ptr >= MEM_DEPTH) with the feature compiled out: index wraps to ptr mod MEM_DEPTH (MEM_DEPTH power of 2).
- Read-after-write to the same address from different ports returns the new value (accesses are serialised).

Optional Feature:
- Macro: FPU_MEMARB_BOUNDS_CHECK_EN.
- When defined, on grant with ptr >= MEM_DEPTH:
  - no SRAM access; the port completes after 1 access cycle.
  - done=1, err[i]=1 and rdata[i]=0 (reads), held while done is high.
  - err clears with done.
- When undefined: err is constant 0 and addresses wrap.

Test Plan:
- Single port c: write ptr=5, wdata=0x3F800000 -> done[2] at cycle 2. Drop avail. Read ptr=5 -> done[2] at cycle 1+RD_LAT, rdata[2]=0x3F800000. done falls the same cycle avail drops.
- Contention: b, c, d all request reads in the same cycle after reset (rr_ptr=0) -> grant order b, c, d. Each done stays high until all three are complete and the requester drops all avail together. No port is re-served while holding avail in CPL.
- Fairness: ports a and d continuously re-request (drop avail one cycle after each done) -> grants alternate a, d, a, d; neither starves.
- Edge cases: avail with r_en=w_en=0 -> no done for 20 cycles. r_en=w_en=1 -> treated as write. RD_LAT=3 -> read done exactly at cycle 4.
- Reset: assert rst_l=0 during READ_WAIT -> next cycle all done=0, rdata=0. After release, a fresh request completes normally.
- Bounds: ptr=MEM_DEPTH+2. Without macro, read returns the word at address 2. With FPU_MEMARB_BOUNDS_CHECK_EN, done=1, err=1, rdata=0, and the word at address 2 is unchanged after a write attempt.

Source files
------------

// File: rtl/fpu_mem_arbiter.sv
// fpu_mem_arbiter: round-robin 4-port scratchpad server with sticky per-port done; FPU_MEMARB_BOUNDS_CHECK_EN flags out-of-range ptr via err
module fpu_mem_arbiter #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int MEM_DEPTH = 1024,
   parameter int RD_LAT    = 1
) (
   input  logic                clk,
   input  logic                rst_l,
   input  logic [3:0]          avail,
   input  logic [3:0]          r_en,
   input  logic [3:0]          w_en,
   input  logic [4*ADDR_W-1:0] ptr,
   input  logic [4*DATA_W-1:0] wdata,
   output logic [3:0]          done,
   output logic [4*DATA_W-1:0] rdata,
   output logic [3:0]          err
);
   localparam int AW = $clog2(MEM_DEPTH);
   typedef enum logic [1:0] {IDLE, PEND, BUSY, CPL} port_st_t;
   typedef enum logic [1:0] {ARB_IDLE, WRITE, READ_WAIT} arb_st_t;
   port_st_t pst [4];
   port_st_t pst_nx [4];
   arb_st_t arb, arb_nx;
   logic [1:0] rr_ptr, cur, gnt, cnt;
   logic gnt_vld, fin, we_q, oob_q, oob;
   logic [3:0] req, err_flag;
   logic [AW-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [ADDR_W-1:0] ptr_sel;
   logic [DATA_W-1:0] mem [MEM_DEPTH];
   logic [DATA_W-1:0] rdata_q [4];
   // an idle port with a live request competes in the same cycle it appears
   always_comb begin
      for (int i = 0; i < 4; i++)
         req[i] = pst[i] == PEND || (pst[i] == IDLE && avail[i] && (r_en[i] || w_en[i]));
      gnt_vld = 1'b0;
      gnt = rr_ptr;
      for (int k = 3; k >= 0; k--)
         if (arb == ARB_IDLE && req[rr_ptr + 2'(k)]) begin
            gnt_vld = 1'b1;
            gnt = rr_ptr + 2'(k);
         end
   end
   assign ptr_sel = ptr[gnt*ADDR_W +: ADDR_W];
   assign fin = arb == WRITE || (arb == READ_WAIT && cnt == 2'(RD_LAT - 1));
`ifdef FPU_MEMARB_BOUNDS_CHECK_EN
   assign oob = ptr_sel >= ADDR_W'(MEM_DEPTH);
`else
   logic unused_ptr_hi;
   assign unused_ptr_hi = ^ptr_sel;
   assign oob = 1'b0;
`endif
   always_comb begin
      arb_nx = arb;
      case (arb)
         ARB_IDLE:  arb_nx = gnt_vld ? ((w_en[gnt] || oob) ? WRITE : READ_WAIT) : ARB_IDLE;
         WRITE:     arb_nx = ARB_IDLE;
         READ_WAIT: arb_nx = fin ? ARB_IDLE : READ_WAIT;
         default:   arb_nx = ARB_IDLE;
      endcase
      for (int i = 0; i < 4; i++) begin
         pst_nx[i] = pst[i];
         case (pst[i])
            IDLE:    pst_nx[i] = (gnt_vld && gnt == 2'(i)) ? BUSY : req[i] ? PEND : IDLE;
            PEND:    pst_nx[i] = (gnt_vld && gnt == 2'(i)) ? BUSY : PEND;
            BUSY:    pst_nx[i] = (fin && cur == 2'(i)) ? CPL : BUSY;
            CPL:     pst_nx[i] = avail[i] ? CPL : IDLE;
            default: pst_nx[i] = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         arb <= ARB_IDLE;
         rr_ptr <= '0;
         cur <= '0;
         cnt <= '0;
         we_q <= 1'b0;
         oob_q <= 1'b0;
         addr_q <= '0;
         wdata_q <= '0;
         err_flag <= '0;
         for (int i = 0; i < 4; i++) begin
            pst[i] <= IDLE;
            rdata_q[i] <= '0;
         end
      end else begin
         arb <= arb_nx;
         for (int i = 0; i < 4; i++) pst[i] <= pst_nx[i];
         cnt <= arb == READ_WAIT ? cnt + 2'd1 : 2'd0;
         if (gnt_vld) begin
            rr_ptr <= gnt + 2'd1;
            cur <= gnt;
            we_q <= w_en[gnt];
            oob_q <= oob;
            addr_q <= ptr_sel[AW-1:0];
            wdata_q <= wdata[gnt*DATA_W +: DATA_W];
         end
         if (fin) begin
            err_flag[cur] <= oob_q;
            if (!we_q) rdata_q[cur] <= oob_q ? '0 : mem[addr_q];
         end
         for (int i = 0; i < 4; i++)
            if (pst[i] == CPL && !avail[i]) err_flag[i] <= 1'b0;
      end
   end
   // SRAM contents survive reset
   always_ff @(posedge clk)
      if (arb == WRITE && we_q && !oob_q) mem[addr_q] <= wdata_q;
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         done[i] = pst[i] == CPL && avail[i];
         err[i] = err_flag[i] && avail[i];
         rdata[i*DATA_W +: DATA_W] = rdata_q[i];
      end
   end
endmodule

// File: tb/tb_fpu_mem_arbiter.sv
// tb_fpu_mem_arbiter: directed bench for fpu_mem_arbiter (RD_LAT=1 main instance, RD_LAT=3 second instance)
module tb_fpu_mem_arbiter;
   localparam int DW = 32;
   localparam int AWD = 32;
   localparam int DEPTH = 1024;
   logic clk = 1'b0;
   logic rst_l;
   logic [3:0] avail, r_en, w_en, done, err;
   logic [4*AWD-1:0] ptr;
   logic [4*DW-1:0] wdata, rdata;
   logic [3:0] avail3, r_en3, w_en3, done3, err3;
   logic [4*AWD-1:0] ptr3;
   logic [4*DW-1:0] wdata3, rdata3;
   int checks = 0;
   int errors = 0;
   int ev [16];
   int n_ev;
   logic any;
   always #5 clk = ~clk;
   fpu_mem_arbiter #(.DATA_W(DW), .ADDR_W(AWD), .MEM_DEPTH(DEPTH), .RD_LAT(1)) dut (
      .clk(clk), .rst_l(rst_l), .avail(avail), .r_en(r_en), .w_en(w_en), .ptr(ptr),
      .wdata(wdata), .done(done), .rdata(rdata), .err(err));
   fpu_mem_arbiter #(.DATA_W(DW), .ADDR_W(AWD), .MEM_DEPTH(DEPTH), .RD_LAT(3)) dut3 (
      .clk(clk), .rst_l(rst_l), .avail(avail3), .r_en(r_en3), .w_en(w_en3), .ptr(ptr3),
      .wdata(wdata3), .done(done3), .rdata(rdata3), .err(err3));
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic logic [31:0] rd(input int i);
      return rdata[i*DW +: DW];
   endfunction
   // request at cycle 0; with RD_LAT=1 both reads and writes complete at cycle 2
   task automatic issue(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d, input string tag);
      ptr[i*AWD +: AWD] = a;
      wdata[i*DW +: DW] = d;
      w_en[i] = wr;
      r_en[i] = !wr;
      avail[i] = 1'b1;
      tick(1);
      chk({tag, "_c1"}, 32'(done[i]), 32'd0);
      tick(1);
      chk({tag, "_c2"}, 32'(done[i]), 32'd1);
   endtask
   task automatic drop_port(input int i);
      avail[i] = 1'b0;
      r_en[i] = 1'b0;
      w_en[i] = 1'b0;
      #1;
      chk("done_drop", 32'(done[i]), 32'd0);
      tick(1);
   endtask
   initial begin
      avail = '0; r_en = '0; w_en = '0; ptr = '0; wdata = '0;
      avail3 = '0; r_en3 = '0; w_en3 = '0; ptr3 = '0; wdata3 = '0;
      rst_l = 1'b0;
      tick(2);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rdata", 32'(|rdata), 32'd0);
      chk("rst_done3", 32'(done3), 32'd0);
      rst_l = 1'b1;
      tick(1);
      issue(2, 1'b1, 32'd5, 32'h3F800000, "c_wr");
      chk("c_wr_rdata_kept", rd(2), 32'd0);
      drop_port(2);
      issue(2, 1'b0, 32'd5, 32'd0, "c_rd");
      chk("c_rd_data", rd(2), 32'h3F800000);
      drop_port(2);
      issue(0, 1'b1, 32'd10, 32'h11, "pre10"); drop_port(0);
      issue(0, 1'b1, 32'd11, 32'h22, "pre11"); drop_port(0);
      issue(0, 1'b1, 32'd12, 32'h33, "pre12"); drop_port(0);
      issue(0, 1'b1, 32'd2, 32'h77, "pre2"); drop_port(0);
      rst_l = 1'b0;
      tick(1);
      rst_l = 1'b1;
      tick(1);
      // contention: b, c, d together with rr_ptr=0
      ptr[1*AWD +: AWD] = 32'd10;
      ptr[2*AWD +: AWD] = 32'd11;
      ptr[3*AWD +: AWD] = 32'd12;
      r_en = 4'b1110;
      avail = 4'b1110;
      tick(1); chk("ct_c1", 32'(done), 32'h0);
      tick(1); chk("ct_c2", 32'(done), 32'h2);
      tick(1); chk("ct_c3", 32'(done), 32'h2);
      tick(1); chk("ct_c4", 32'(done), 32'h6);
      tick(2); chk("ct_c6", 32'(done), 32'he);
      tick(4); chk("ct_hold", 32'(done), 32'he);
      chk("ct_rd_b", rd(1), 32'h11);
      chk("ct_rd_c", rd(2), 32'h22);
      chk("ct_rd_d", rd(3), 32'h33);
      avail = '0;
      r_en = '0;
      #1;
      chk("ct_drop", 32'(done), 32'h0);
      tick(1);
      // fairness: a and d re-request one cycle after each completion
      ptr[0*AWD +: AWD] = 32'd10;
      ptr[3*AWD +: AWD] = 32'd12;
      r_en = 4'b1001;
      avail = 4'b1001;
      n_ev = 0;
      for (int c = 0; c < 16; c++) begin
         tick(1);
         if (done[0]) begin
            if (n_ev < 16) ev[n_ev] = 0;
            n_ev++;
            avail[0] = 1'b0;
         end else if (!avail[0]) avail[0] = 1'b1;
         if (done[3]) begin
            if (n_ev < 16) ev[n_ev] = 3;
            n_ev++;
            avail[3] = 1'b0;
         end else if (!avail[3]) avail[3] = 1'b1;
      end
      chk("fair_count", 32'(n_ev), 32'd8);
      for (int k = 0; k < 8; k++) chk("fair_order", 32'(ev[k]), (k % 2) ? 32'd3 : 32'd0);
      chk("fair_rd_a", rd(0), 32'h11);
      chk("fair_rd_d", rd(3), 32'h33);
      avail = '0;
      r_en = '0;
      tick(3);
      // no-op request never completes
      avail[1] = 1'b1;
      any = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick(1);
         any |= done[1];
      end
      chk("noop_done", 32'(any), 32'd0);
      avail[1] = 1'b0;
      tick(1);
      // r_en and w_en together act as a write
      ptr[1*AWD +: AWD] = 32'd20;
      wdata[1*DW +: DW] = 32'hDEADBEEF;
      r_en[1] = 1'b1;
      w_en[1] = 1'b1;
      avail[1] = 1'b1;
      tick(2);
      chk("rw_done", 32'(done[1]), 32'd1);
      chk("rw_rdata_kept", rd(1), 32'h11);
      drop_port(1);
      issue(0, 1'b0, 32'd20, 32'd0, "rw_rd");
      chk("rw_rd_data", rd(0), 32'hDEADBEEF);
      drop_port(0);
      // reset while a read sits in READ_WAIT
      ptr[0*AWD +: AWD] = 32'd10;
      r_en[0] = 1'b1;
      avail[0] = 1'b1;
      tick(1);
      rst_l = 1'b0;
      tick(1);
      chk("mid_rst_done", 32'(done), 32'h0);
      chk("mid_rst_rdata", 32'(|rdata), 32'd0);
      avail = '0;
      r_en = '0;
      rst_l = 1'b1;
      tick(1);
      issue(0, 1'b0, 32'd11, 32'd0, "post_rst");
      chk("post_rst_data", rd(0), 32'h22);
      drop_port(0);
`ifdef FPU_MEMARB_BOUNDS_CHECK_EN
      issue(3, 1'b0, 32'd12, 32'd0, "oob_pre");
      drop_port(3);
      issue(3, 1'b1, DEPTH + 2, 32'h99, "oob_wr");
      chk("oob_wr_err", 32'(err[3]), 32'd1);
      drop_port(3);
      chk("oob_err_clr", 32'(err), 32'd0);
      issue(3, 1'b0, DEPTH + 2, 32'd0, "oob_rd");
      chk("oob_rd_err", 32'(err[3]), 32'd1);
      chk("oob_rd_zero", rd(3), 32'd0);
      drop_port(3);
      issue(3, 1'b0, 32'd2, 32'd0, "oob_keep");
      chk("oob_keep_data", rd(3), 32'h77);
      drop_port(3);
`else
      issue(3, 1'b0, DEPTH + 2, 32'd0, "wrap_rd");
      chk("wrap_data", rd(3), 32'h77);
      chk("wrap_err", 32'(err), 32'd0);
      drop_port(3);
`endif
      // RD_LAT=3 instance: write done at cycle 2, read done exactly at cycle 4
      ptr3[31:0] = 32'd7;
      wdata3[31:0] = 32'hA5;
      w_en3[0] = 1'b1;
      avail3[0] = 1'b1;
      tick(1); chk("l3_wr_c1", 32'(done3[0]), 32'd0);
      tick(1); chk("l3_wr_c2", 32'(done3[0]), 32'd1);
      avail3[0] = 1'b0;
      w_en3[0] = 1'b0;
      tick(1);
      r_en3[0] = 1'b1;
      avail3[0] = 1'b1;
      tick(3); chk("l3_rd_c3", 32'(done3[0]), 32'd0);
      tick(1); chk("l3_rd_c4", 32'(done3[0]), 32'd1);
      chk("l3_rd_data", rdata3[31:0], 32'hA5);
      avail3[0] = 1'b0;
      #1;
      chk("l3_drop", 32'(done3[0]), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
